wb_arbiter: RTL and testbench

- Writeback stage that sits directly upstream of the register file write port (we/waddr/wdata).
- Merges two result sources into the single write port:
  - in-order pipeline results from MEM/WB;
  - out-of-order results from long-latency units (divider, multiplier), which arrive over a valid/ready handshake and are buffered in a small FIFO.
- Keeps a per-register busy scoreboard so decode can stall on operands still pending in long-latency units.
- Raises a stall request when the FIFO is starved by pipeline writes.

---
 rtl/wb_arbiter_pkg.sv | 16 +
 rtl/wb_arbiter_if.sv | 42 ++++
 rtl/wb_fifo.sv | 54 +++++
 rtl/wb_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the writeback arbiter slice.
// Names mirror the RegBus / RegAddrBus / WbFifoDepth / WbStarveMax core defines.
package wb_arbiter_pkg;

  localparam int REG_BUS       = 32;
  localparam int REG_ADDR_BUS  = 5;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_STARVE_MAX = 4;

  // ARB_DRAIN is the stall_req state: pipe ignored, FIFO drained.
  typedef enum logic {
    ARB_RUN   = 1'b0,
    ARB_DRAIN = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback port bundle: MEM/WB input, long-latency handshake, issue
// notification and the registered regfile write port.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_BUS,
  parameter int ADDR_W = REG_ADDR_BUS
) ();

  // lu handshake: a result transfers on a cycle where lu_valid && lu_ready.
  // lu_ready depends only on registered state, never on lu_valid.
  logic                 pipe_we;
  logic [ADDR_W-1:0]    pipe_waddr;
  logic [DATA_W-1:0]    pipe_wdata;
  logic                 lu_valid;
  logic                 lu_ready;
  logic [ADDR_W-1:0]    lu_waddr;
  logic [DATA_W-1:0]    lu_wdata;
  logic                 issue_valid;
  logic [ADDR_W-1:0]    issue_waddr;
  logic                 we;
  logic [ADDR_W-1:0]    waddr;
  logic [DATA_W-1:0]    wdata;
  logic [2**ADDR_W-1:0] busy;
  logic                 stall_req;
  arb_state_t           state;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output lu_valid, lu_waddr, lu_wdata,
    output issue_valid, issue_waddr,
    input  lu_ready, we, waddr, wdata, busy, stall_req, state
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  lu_valid, lu_waddr, lu_wdata,
    input  issue_valid, issue_waddr,
    output lu_ready, we, waddr, wdata, busy, stall_req, state
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO, power-of-two depth, combinational head read.
// Push while full and pop while empty are ignored.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges MEM/WB writes with buffered long-latency results
// onto one registered regfile port, tracks pending writes, forces FIFO drains.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_W     = REG_BUS,
  parameter int ADDR_W     = REG_ADDR_BUS,
  parameter int DEPTH      = WB_FIFO_DEPTH,
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  localparam int ENTRY_W  = ADDR_W + DATA_W;
  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int NREG     = 2**ADDR_W;

  logic [ENTRY_W-1:0]  head;
  logic [ADDR_W-1:0]   head_waddr;
  logic [DATA_W-1:0]   head_wdata;
  logic [CNT_W-1:0]    count;
  logic                full, empty;
  logic                push, pop, pipe_hit, starve_inc;

  arb_state_t          state_q, state_d;
  logic [STARVE_W-1:0] starve_q;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NREG-1:0]     busy_q, busy_d;

  assign head_waddr = head[ENTRY_W-1:DATA_W];
  assign head_wdata = head[DATA_W-1:0];

  assign bus.lu_ready = !rst && !full;
  assign push         = bus.lu_valid && bus.lu_ready;
  assign pipe_hit     = bus.pipe_we && (bus.pipe_waddr != '0) && (state_q == ARB_RUN);
  assign pop          = !pipe_hit && !empty;
  assign starve_inc   = pipe_hit && !empty;

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({bus.lu_waddr, bus.lu_wdata}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_RUN;
      starve_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_inc ? starve_q + STARVE_W'(1) : '0;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  // Drain until the pop that leaves the FIFO empty; the empty check only
  // guards against ever sitting in ARB_DRAIN with nothing to pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_RUN: begin
        if (starve_inc && (starve_q == STARVE_W'(STARVE_MAX - 1))) state_d = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        if (empty || ((count == CNT_W'(1)) && pop && !push)) state_d = ARB_RUN;
      end
      default: state_d = ARB_RUN;
    endcase
  end

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (pipe_hit) begin
      we_d    = 1'b1;
      waddr_d = bus.pipe_waddr;
      wdata_d = bus.pipe_wdata;
    end else if (pop) begin
      we_d    = (head_waddr != '0);
      waddr_d = head_waddr;
      wdata_d = head_wdata;
    end
  end

  // A new issue to the register being retired keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head_waddr] = 1'b0;
    if (bus.issue_valid && (bus.issue_waddr != '0)) busy_d[bus.issue_waddr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.stall_req = (state_q == ARB_DRAIN);
  assign bus.state     = state_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scenarios then random traffic against a queue-based reference
// model of the writeback arbiter.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_arbiter #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // reference model state
  ent_t                     m_q[$];
  logic [2**ADDR_W-1:0]     m_busy;
  int                       m_starve;
  bit                       m_stall;
  logic                     m_we;
  logic [ADDR_W-1:0]        m_waddr;
  logic [DATA_W-1:0]        m_wdata;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pd,
                       input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                       input logic iv, input logic [ADDR_W-1:0] ia);
    bus.pipe_we     = pwe;
    bus.pipe_waddr  = pa;
    bus.pipe_wdata  = pd;
    bus.lu_valid    = lv;
    bus.lu_waddr    = la;
    bus.lu_wdata    = ld;
    bus.issue_valid = iv;
    bus.issue_waddr = ia;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // Advance the model one cycle from the applied inputs, clock the DUT, compare.
  task automatic step();
    int   sz;
    bit   push, hit, pop;
    ent_t head;
    ent_t in_ent;
    #1;
    check("lu_ready", bus.lu_ready, (!rst && m_q.size() < DEPTH));
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_busy = '0; m_starve = 0; m_stall = 0;
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    end else begin
      sz   = m_q.size();
      push = bus.lu_valid && (sz < DEPTH);
      hit  = bus.pipe_we && (bus.pipe_waddr != 0) && !m_stall;
      pop  = !hit && (sz > 0);
      head = pop ? m_q[0] : '0;
      if (hit) begin
        m_we = 1'b1; m_waddr = bus.pipe_waddr; m_wdata = bus.pipe_wdata;
      end else if (pop) begin
        m_we = (head.a != 0); m_waddr = head.a; m_wdata = head.d;
      end else begin
        m_we = 1'b0;
      end
      if (m_we) exp_q.push_back({m_waddr, m_wdata});
      if (m_stall) begin
        m_starve = 0;
        m_stall  = (sz - int'(pop) + int'(push)) != 0;
      end else if (hit && sz > 0) begin
        m_starve++;
        m_stall = (m_starve == STARVE_MAX);
      end else begin
        m_starve = 0;
      end
      if (pop) m_busy[head.a] = 1'b0;
      if (bus.issue_valid && bus.issue_waddr != 0) m_busy[bus.issue_waddr] = 1'b1;
      m_busy[0] = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        in_ent.a = bus.lu_waddr;
        in_ent.d = bus.lu_wdata;
        m_q.push_back(in_ent);
      end
    end
    @(posedge clk);
    #1;
    check("we", bus.we, m_we);
    check("waddr", bus.waddr, m_waddr);
    check("wdata", bus.wdata, m_wdata);
    check("busy", bus.busy, m_busy);
    check("stall_req", bus.stall_req, m_stall);
    if (bus.we !== 1'b0) begin
      if (exp_q.size() > 0) check("sb_write", {bus.waddr, bus.wdata}, exp_q.pop_front());
      else check("sb_unexpected_we", bus.we, 1'b0);
    end
    @(negedge clk);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    idle();
    step();
    step();
    check("rst_we", bus.we, 1'b0);
    check("rst_busy", bus.busy, '0);
    rst = 1'b0;

    // pipe only
    drive(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, 1'b0, '0);
    step();
    check("pipe_we", bus.we, 1'b1);
    check("pipe_waddr", bus.waddr, 5'd5);
    check("pipe_wdata", bus.wdata, 32'h1234);
    check("pipe_busy", bus.busy, '0);

    // long-latency result with scoreboard
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
    step();
    check("issue_busy7", bus.busy[7], 1'b1);
    idle(); step();
    drive(1'b0, '0, '0, 1'b1, 5'd7, 32'hDEAD, 1'b0, '0);
    step();
    check("lu_push_no_bypass", bus.we, 1'b0);
    idle(); step();
    check("lu_we", bus.we, 1'b1);
    check("lu_waddr", bus.waddr, 5'd7);
    check("lu_wdata", bus.wdata, 32'hDEAD);
    check("lu_busy7_clr", bus.busy[7], 1'b0);

    // priority: pipe first, LU next
    drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0, '0);
    step();
    check("prio_first", bus.waddr, 5'd3);
    idle(); step();
    check("prio_second", {bus.we, bus.waddr}, {1'b1, 5'd4});

    // FIFO full then recover after first pop
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 32'h100, 1'b0, '0);
    step();
    drive(1'b1, 5'd1, 32'h12, 1'b1, 5'd11, 32'h101, 1'b0, '0);
    step();
    check("full_ready", bus.lu_ready, 1'b0);
    idle(); step();
    check("full_recover", bus.lu_ready, 1'b1);
    idle(); step();

    // starvation: one entry held while pipe wins four cycles
    drive(1'b1, 5'd2, 32'h20, 1'b1, 5'd12, 32'hC0DE, 1'b0, '0);
    step();
    for (int i = 0; i < STARVE_MAX; i++) begin
      drive(1'b1, 5'd2, 32'h21, 1'b0, '0, '0, 1'b0, '0);
      step();
    end
    check("starve_stall", bus.stall_req, 1'b1);
    step();
    check("starve_drain", {bus.we, bus.waddr, bus.wdata}, {1'b1, 5'd12, 32'hC0DE});
    check("starve_clear", bus.stall_req, 1'b0);
    step();
    check("starve_pipe_resume", bus.wdata, 32'h21);

    // pipe write to reg0 is dropped
    drive(1'b1, 5'd0, 32'h55, 1'b0, '0, '0, 1'b0, '0);
    step();
    check("reg0_we", bus.we, 1'b0);

    // issue and retire the same register in one cycle: set wins
    drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h99, 1'b0, '0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
    step();
    check("set_wins_we", {bus.we, bus.waddr}, {1'b1, 5'd9});
    check("set_wins_busy9", bus.busy[9], 1'b1);

    // reset with two entries queued
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd13, 32'h13, 1'b1, 5'd13);
    step();
    drive(1'b1, 5'd1, 32'h2, 1'b1, 5'd14, 32'h14, 1'b1, 5'd14);
    step();
    idle();
    rst = 1'b1;
    step();
    check("rst_mid_ready", bus.lu_ready, 1'b0);
    check("rst_mid_busy", bus.busy, '0);
    rst = 1'b0;
    step();
    check("rst_mid_no_write1", bus.we, 1'b0);
    step();
    check("rst_mid_no_write2", bus.we, 1'b0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(logic'($urandom_range(0, 99) < 60), ADDR_W'($urandom_range(0, 31)), $urandom(),
            logic'($urandom_range(0, 99) < 45), ADDR_W'($urandom_range(0, 31)), $urandom(),
            logic'($urandom_range(0, 99) < 30), ADDR_W'($urandom_range(0, 31)));
      step();
    end
    rst = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
